// File: rtl/seq_digit_adder_if.sv
// Handshake and operand/result bundle for seq_digit_adder.
// The master side issues start/operands; the slave side (the adder) returns status and result.
interface seq_digit_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice walks the operands LSB digit first,
// linked by a registered carry; sum/cout/ovf update only on the completion edge.
//
// state | meaning
// IDLE  | waiting for start, previous result held on sum/cout/ovf
// RUN   | one digit processed per clock, busy=1
// DONE  | result just loaded, done=1 for this cycle, start accepted
module seq_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    seq_digit_adder_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("seq_digit_adder: WIDTH must be an integer multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             busy_c;
    logic             done_c;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] opa_shift;
    logic [WIDTH-1:0] opb_shift;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT:0]   dig_full;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             top_cin;
    logic [WIDTH-1:0] result;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    // A new operation is taken whenever busy is low, including the DONE cycle.
    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            RUN:     busy_c = 1'b1;
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    assign dig_a    = opa[DIGIT-1:0];
    assign dig_b    = opb[DIGIT-1:0];
    assign dig_full = {1'b0, dig_a} + {1'b0, dig_b} + (DIGIT + 1)'(carry);
    assign dig_sum  = dig_full[DIGIT-1:0];
    assign dig_cout = dig_full[DIGIT];
    // Carry into the digit's top bit recovered from that bit's sum: s = a ^ b ^ c_in.
    assign top_cin  = dig_a[DIGIT-1] ^ dig_b[DIGIT-1] ^ dig_sum[DIGIT-1];

    if (NDIG > 1) begin : g_multi
        logic [WIDTH-DIGIT-1:0] part;

        // Finished digits enter from the top, so after NDIG steps digit 0 sits at the bottom.
        always_ff @(posedge clk) begin
            if (rst) begin
                part <= '0;
            end else if (state == RUN) begin
                part <= result[WIDTH-1:DIGIT];
            end
        end

        assign result    = {dig_sum, part};
        assign opa_shift = {{DIGIT{1'b0}}, opa[WIDTH-1:DIGIT]};
        assign opb_shift = {{DIGIT{1'b0}}, opb[WIDTH-1:DIGIT]};
    end else begin : g_single
        assign result    = dig_sum;
        assign opa_shift = opa;
        assign opb_shift = opb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa   <= opa_shift;
            opb   <= opb_shift;
            carry <= dig_cout;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum_q  <= result;
                cout_q <= dig_cout;
                ovf_q  <= top_cin ^ dig_cout;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_digit_adder.sv
// Bench for seq_digit_adder: three instances (DIGIT 4, 16, 1) share operands and are
// compared with an integer-arithmetic reference model, plus directed handshake/reset cases.
module tb_seq_digit_adder;
    localparam int W = 16;
    localparam int NDIG_OF [3] = '{4, 1, 16};
    localparam int DIGIT_OF [3] = '{4, 16, 1};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_digit_adder_if #(.WIDTH(W)) if4 ();
    seq_digit_adder_if #(.WIDTH(W)) if16 ();
    seq_digit_adder_if #(.WIDTH(W)) if1 ();

    seq_digit_adder #(.WIDTH(W), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    seq_digit_adder #(.WIDTH(W), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    seq_digit_adder #(.WIDTH(W), .DIGIT(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

    int checks = 0;
    int errors = 0;

    logic         busy_v [3];
    logic         done_v [3];
    logic [W-1:0] sum_v  [3];
    logic         cout_v [3];
    logic         ovf_v  [3];

    task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s [digit=%0d] observed=%0h expected=%0h", tag, DIGIT_OF[inst], obs, exp);
        end
    endtask

    task automatic sample();
        busy_v[0] = if4.busy;  done_v[0] = if4.done;  sum_v[0] = if4.sum;
        cout_v[0] = if4.cout;  ovf_v[0]  = if4.ovf;
        busy_v[1] = if16.busy; done_v[1] = if16.done; sum_v[1] = if16.sum;
        cout_v[1] = if16.cout; ovf_v[1]  = if16.ovf;
        busy_v[2] = if1.busy;  done_v[2] = if1.done;  sum_v[2] = if1.sum;
        cout_v[2] = if1.cout;  ovf_v[2]  = if1.ovf;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
        if4.a  = a; if4.b  = b; if4.sub  = s; if4.cin  = c;
        if16.a = a; if16.b = b; if16.sub = s; if16.cin = c;
        if1.a  = a; if1.b  = b; if1.sub  = s; if1.cin  = c;
    endtask

    task automatic set_start(input logic [2:0] en);
        if4.start  = en[0];
        if16.start = en[1];
        if1.start  = en[2];
    endtask

    task automatic drive_noise();
        drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c,
                             output logic [W-1:0] r_sum, output logic r_cout, output logic r_ovf);
        int u;
        int sv;
        if (!s) begin
            u      = int'(a) + int'(b) + int'(c);
            r_cout = (u > 65535);
            sv     = int'($signed(a)) + int'($signed(b)) + int'(c);
        end else begin
            u      = int'(a) - int'(b) - int'(c);
            r_cout = (u >= 0);
            sv     = int'($signed(a)) - int'($signed(b)) - int'(c);
        end
        r_sum = u[W-1:0];
        r_ovf = (sv > 32767) || (sv < -32768);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    // Starts the enabled instances at the current negedge and follows them to completion.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, input logic [2:0] en, input bit tail);
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
        logic [W-1:0] prev_sum [3];
        int           nbusy [3];
        int           done_at [3];
        bit           pending;
        ref_model(a, b, s, c, exp_sum, exp_cout, exp_ovf);
        sample();
        for (int i = 0; i < 3; i++) begin
            prev_sum[i] = sum_v[i];
            nbusy[i]    = 0;
            done_at[i]  = -1;
        end
        drive(a, b, s, c);
        set_start(en);
        @(negedge clk);
        set_start(3'b000);
        drive_noise();
        for (int cyc = 0; cyc < 40; cyc++) begin
            sample();
            pending = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!en[i]) continue;
                if (done_at[i] < 0) begin
                    if (cyc == 0) begin
                        chk({tag, "/busy_first"}, i, busy_v[i], 1);
                        chk({tag, "/done_first"}, i, done_v[i], 0);
                    end
                    if (done_v[i]) begin
                        done_at[i] = cyc;
                        chk({tag, "/busy_cycles"}, i, nbusy[i], NDIG_OF[i]);
                        chk({tag, "/sum"}, i, sum_v[i], exp_sum);
                        chk({tag, "/cout"}, i, cout_v[i], exp_cout);
                        chk({tag, "/ovf"}, i, ovf_v[i], exp_ovf);
                    end else begin
                        if (busy_v[i]) nbusy[i]++;
                        chk({tag, "/sum_hold"}, i, sum_v[i], prev_sum[i]);
                        pending = 1'b1;
                    end
                end else if (cyc == done_at[i] + 1) begin
                    chk({tag, "/done_pulse"}, i, done_v[i], 0);
                end
            end
            if (!pending) break;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            if (en[i] && done_at[i] < 0) chk({tag, "/timeout"}, i, 0, 1);
        end
        if (tail) begin
            @(negedge clk);
            sample();
            for (int i = 0; i < 3; i++) begin
                if (!en[i]) continue;
                chk({tag, "/tail_done"}, i, done_v[i], 0);
                chk({tag, "/tail_busy"}, i, busy_v[i], 0);
                chk({tag, "/tail_sum"}, i, sum_v[i], exp_sum);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int done_cyc;
        rst = 1'b1;
        set_start(3'b000);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        sample();
        for (int i = 0; i < 3; i++) begin
            chk("reset/busy", i, busy_v[i], 0);
            chk("reset/done", i, done_v[i], 0);
            chk("reset/sum", i, sum_v[i], 0);
            chk("reset/cout", i, cout_v[i], 0);
            chk("reset/ovf", i, ovf_v[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 3'b111, 1'b1);
        run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'b111, 1'b1);
        run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'b111, 1'b1);
        run_op("add_cin",  16'h0000, 16'h0000, 1'b0, 1'b1, 3'b111, 1'b1);
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b0, 3'b111, 1'b1);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b0, 3'b111, 1'b1);
        run_op("sub_bin",  16'h0010, 16'h0003, 1'b1, 1'b1, 3'b111, 1'b1);

        // Start while busy must be ignored.
        drive(16'h0001, 16'h0001, 1'b0, 1'b0);
        set_start(3'b001);
        @(negedge clk);
        set_start(3'b000);
        sample();
        chk("ignore/busy1", 0, busy_v[0], 1);
        @(negedge clk);
        drive(16'h7000, 16'h1234, 1'b1, 1'b1);
        set_start(3'b001);
        @(negedge clk);
        set_start(3'b000);
        drive_noise();
        got = 1'b0;
        done_cyc = -1;
        for (int cyc = 0; cyc < 12 && !got; cyc++) begin
            sample();
            if (done_v[0]) begin
                got = 1'b1;
                done_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("ignore/done_seen", 0, got, 1);
        chk("ignore/done_cycle", 0, done_cyc, 2);
        chk("ignore/sum", 0, sum_v[0], 16'h0002);
        chk("ignore/cout", 0, cout_v[0], 0);
        chk("ignore/ovf", 0, ovf_v[0], 0);

        // Back-to-back: start issued in the done cycle.
        run_op("b2b", 16'h00FF, 16'h0001, 1'b0, 1'b0, 3'b001, 1'b1);

        // Reset on the second busy cycle, with a start alongside it.
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        set_start(3'b001);
        @(negedge clk);
        set_start(3'b000);
        @(negedge clk);
        rst = 1'b1;
        set_start(3'b001);
        @(negedge clk);
        rst = 1'b0;
        set_start(3'b000);
        sample();
        chk("midrst/busy", 0, busy_v[0], 0);
        chk("midrst/done", 0, done_v[0], 0);
        chk("midrst/sum", 0, sum_v[0], 0);
        chk("midrst/cout", 0, cout_v[0], 0);
        chk("midrst/ovf", 0, ovf_v[0], 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sample();
            chk("midrst/quiet_busy", 0, busy_v[0], 0);
            chk("midrst/quiet_done", 0, done_v[0], 0);
        end
        run_op("post_rst", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 3'b111, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), pick_operand(), pick_operand(),
                   1'($urandom), 1'($urandom), 3'b111, 1'($urandom));
        end
        run_op("final", 16'h1234, 16'h4321, 1'b1, 1'b0, 3'b111, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
